input_line_buffer: RTL
======================

Name: input_line_buffer

Overview:
Three-row line buffer between the AXI-Stream input feature-map port and the PE array of the conv2d datapath. It executes one row command at a time from the conv control unit (Stream_first_row / Stream_mid_row / Stream_last_row), loads the required input rows from the stream, then emits zero-padded 3-pixel columns to PE_with_buffers. It reports Done_1row and Input_line_buffer_IDLE back to the control unit.

Parameters:
DATA_WIDTH, 16, pixel width (bits)
MAX_IMAGE_SIZE, 128, row slot depth; largest supported IMAGE_SIZE

Ports:
clk  in  1  system clock
aresetn  in  1  synchronous active-low reset
Input_line_buffer_Reset  in  1  synchronous active-low local reset from the control unit; same effect as aresetn
IMAGE_SIZE  in  8  row length in pixels: 4, 8, 16, 32, 64 or 128; sampled at command accept
Stream_first_row  in  1  command pulse: top output row of a channel
Stream_mid_row  in  1  command pulse: interior output row
Stream_last_row  in  1  command pulse: bottom output row
s_axis_tdata  in  DATA_WIDTH  input pixel
s_axis_tvalid  in  1  input valid
s_axis_tlast  in  1  last pixel of an input row
s_axis_tready  out  1  input ready
m_col_top  out  DATA_WIDTH  window column, top pixel
m_col_mid  out  DATA_WIDTH  window column, middle pixel
m_col_bot  out  DATA_WIDTH  window column, bottom pixel
m_col_first  out  1  marks column 0 (left pad)
m_col_last  out  1  marks column IMAGE_SIZE+1 (right pad)
m_col_valid  out  1  column valid
m_col_ready  in  1  PE accepts column
Done_1row  out  1  one-cycle pulse after last column accepted
Input_line_buffer_IDLE  out  1  high only in S_IDLE
row_len_err  out  1  sticky tlast mismatch flag (see Optional Feature)

Behaviour:
- Reset (either reset low): state S_IDLE, ptr=0, pad_top=0, pad_bot=0, counters 0, all outputs 0 except Input_line_buffer_IDLE=1. Slot contents are not cleared. Reset mid-load or mid-emit aborts immediately; no Done_1row is produced.
- Storage: three slots of MAX_IMAGE_SIZE x DATA_WIDTH, asynchronous read (distributed RAM). Logical rows: top=slot[ptr], mid=slot[(ptr+1)%3], bot=slot[(ptr+2)%3].
- States: S_IDLE, S_LOAD, S_EMIT, S_DONE.
- S_IDLE: commands are accepted only here; priority first > mid > last when several are asserted together. Commands in any other state are ignored.
  - first: ptr<=0, pad_top<=1, pad_bot<=0, rows_to_load<=2, load slot 1 then slot 2. Go to S_LOAD.
  - mid: ptr<=(ptr+1)%3, pad_top<=0, rows_to_load<=1, load slot (new ptr+2)%3. Go to S_LOAD.
  - last: ptr<=(ptr+1)%3, pad_bot<=1, rows_to_load<=0. Go directly to S_EMIT.
- S_LOAD: s_axis_tready=1. Each beat with tvalid&&tready writes pix_cnt and increments it. At pix_cnt==IMAGE_SIZE-1 accepted: pix_cnt<=0 and rows_to_load decrements. When it reaches 0, go to S_EMIT. tready=0 in all other states.
- S_EMIT: col_cnt runs 0..IMAGE_SIZE+1 and m_col_valid=1.
  - Columns 0 and IMAGE_SIZE+1 are all zero. Column c otherwise reads pixel c-1.
  - pad_top forces m_col_top=0; pad_bot forces m_col_bot=0.
  - Outputs hold stable while valid&&!ready; col_cnt advances on valid&&ready.
  - First column is valid the cycle after S_EMIT is entered.
  - Acceptance of column IMAGE_SIZE+1 goes to S_DONE.
- S_DONE: Done_1row=1 for exactly one cycle, then S_IDLE.
- Widths: pix_cnt and col_cnt are 8 bits; IMAGE_SIZE+1 is computed in 8 bits (max 129).

Optional Feature:
Macro ILB_TLAST_CHECK_EN.
- Defined: row_len_err is set sticky when s_axis_tlast is asserted on an accepted beat with pix_cnt!=IMAGE_SIZE-1, or is deasserted on the beat where pix_cnt==IMAGE_SIZE-1. It is cleared only by reset. Loading continues purely by count regardless.
- Undefined: tlast is ignored and row_len_err is tied to 0.

Decomposition:
- Shared package conv_pkg: DATA_WIDTH, MAX_IMAGE_SIZE, the ILB state encoding (2-bit localparams), and the IMAGE_SIZE_choose-to-size mapping constants shared with the control unit.
- One sub-module, ilb_row_slot: a single-write, async-read row RAM, instantiated three times.

Test Plan:
1. IMAGE_SIZE=4; first command; stream pixels 1..8 → tready for 8 beats, then 6 columns (top,mid,bot): (0,0,0),(0,1,5),(0,2,6),(0,3,7),(0,4,8),(0,0,0); m_col_first on col0, m_col_last on col5; Done_1row one pulse; IDLE returns.
2. Continue: mid command with pixels 9..12 → columns (1,5,9)..(4,8,12) between zero pads; then last command with no stream beats → (5,9,0)..(8,12,0).
3. m_col_ready toggling 1/0 every cycle during emit → each column held stable until accepted; exactly IMAGE_SIZE+2 acceptances; Done_1row after the final one.
4. s_axis_tvalid gaps during load plus Stream_mid_row pulsed while in S_EMIT → loaded data correct, spurious command ignored, IDLE low throughout.
5. aresetn low for one cycle mid-emit → next cycle S_IDLE, IDLE=1, m_col_valid=0, no Done_1row; a subsequent first command works from ptr=0.
6. With ILB_TLAST_CHECK_EN defined and IMAGE_SIZE=8, tlast on beat 6 → row_len_err=1 and stays set after row completes; undefined build → row_len_err stays 0.

Source files
------------

// File: rtl/conv_pkg.sv
// ---------------------------------------------------------------------------
// conv_pkg - constants, ILB state encoding and size mapping for conv2d. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package conv_pkg;

   localparam int DATA_WIDTH     = 16;
   localparam int MAX_IMAGE_SIZE = 128;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_EMIT = 2'd2,
      S_DONE = 2'd3
   } ilb_state_t;

   // IMAGE_SIZE_choose codes as driven by the control unit
   localparam logic [2:0] SIZE_CHOOSE_4   = 3'd0;
   localparam logic [2:0] SIZE_CHOOSE_8   = 3'd1;
   localparam logic [2:0] SIZE_CHOOSE_16  = 3'd2;
   localparam logic [2:0] SIZE_CHOOSE_32  = 3'd3;
   localparam logic [2:0] SIZE_CHOOSE_64  = 3'd4;
   localparam logic [2:0] SIZE_CHOOSE_128 = 3'd5;

   function automatic logic [7:0] size_from_choose(input logic [2:0] choose);
      case (choose)
         SIZE_CHOOSE_4:   return 8'd4;
         SIZE_CHOOSE_8:   return 8'd8;
         SIZE_CHOOSE_16:  return 8'd16;
         SIZE_CHOOSE_32:  return 8'd32;
         SIZE_CHOOSE_64:  return 8'd64;
         default:         return 8'd128;
      endcase
   endfunction

   function automatic logic [1:0] mod3(input logic [2:0] v);
      return (v >= 3'd3) ? 2'(v - 3'd3) : v[1:0];
   endfunction

   function automatic logic [1:0] mod3_inc(input logic [1:0] p);
      return (p == 2'd2) ? 2'd0 : p + 2'd1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/ilb_row_slot.sv
// ---------------------------------------------------------------------------
// ilb_row_slot - one row of pixels, synchronous write, asynchronous read. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ilb_row_slot
   import conv_pkg::*;
#(
   parameter int SLOT_WIDTH = DATA_WIDTH,
   parameter int DEPTH      = MAX_IMAGE_SIZE,
   parameter int ADDR_W     = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  wr_en,
   input  logic [ADDR_W-1:0]     wr_addr,
   input  logic [SLOT_WIDTH-1:0] wr_data,
   input  logic [ADDR_W-1:0]     rd_addr,
   output logic [SLOT_WIDTH-1:0] rd_data
);

   logic [SLOT_WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

`default_nettype wire

// File: rtl/input_line_buffer.sv
// ---------------------------------------------------------------------------
// input_line_buffer - 3-row line buffer feeding padded columns to the PE array;
// tlast length checking enabled by macro ILB_TLAST_CHECK_EN. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module input_line_buffer #(
   parameter int DATA_WIDTH     = conv_pkg::DATA_WIDTH,
   parameter int MAX_IMAGE_SIZE = conv_pkg::MAX_IMAGE_SIZE
) (
   input  logic                  clk,
   input  logic                  aresetn,
   input  logic                  Input_line_buffer_Reset,
   input  logic [7:0]            IMAGE_SIZE,
   input  logic                  Stream_first_row,
   input  logic                  Stream_mid_row,
   input  logic                  Stream_last_row,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic                  s_axis_tvalid,
   input  logic                  s_axis_tlast,
   output logic                  s_axis_tready,
   output logic [DATA_WIDTH-1:0] m_col_top,
   output logic [DATA_WIDTH-1:0] m_col_mid,
   output logic [DATA_WIDTH-1:0] m_col_bot,
   output logic                  m_col_first,
   output logic                  m_col_last,
   output logic                  m_col_valid,
   input  logic                  m_col_ready,
   output logic                  Done_1row,
   output logic                  Input_line_buffer_IDLE,
   output logic                  row_len_err
);
   import conv_pkg::*;

   localparam int ADDR_W = $clog2(MAX_IMAGE_SIZE);

   ilb_state_t state, state_nxt;
   logic       rst_ok;
   logic [1:0] ptr, rows_to_load, load_slot;
   logic       pad_top, pad_bot;
   logic [7:0] pix_cnt, col_cnt, img_size, col_last_idx, col_m1;
   logic       beat, row_end, col_accept, col_is_first, col_is_last, pad_col;
   logic [2:0] slot_we;
   logic [DATA_WIDTH-1:0] slot_rd [3];
   logic [1:0] top_idx, mid_idx, bot_idx;

   assign rst_ok       = aresetn & Input_line_buffer_Reset;
   assign beat         = (state == S_LOAD) && s_axis_tvalid;
   assign row_end      = (pix_cnt == img_size - 8'd1);
   assign col_last_idx = img_size + 8'd1;
   assign col_is_first = (col_cnt == 8'd0);
   assign col_is_last  = (col_cnt == col_last_idx);
   assign pad_col      = col_is_first | col_is_last;
   assign col_accept   = m_col_valid && m_col_ready;
   assign col_m1       = col_cnt - 8'd1;

   // Rows still to come fill the slots below the top one, nearest first.
   assign load_slot = mod3({1'b0, ptr} + 3'd3 - {1'b0, rows_to_load});
   assign top_idx   = ptr;
   assign mid_idx   = mod3_inc(ptr);
   assign bot_idx   = mod3_inc(mid_idx);

   for (genvar i = 0; i < 3; i++) begin : g_slot
      assign slot_we[i] = beat && (load_slot == 2'(i));
      ilb_row_slot #(
         .SLOT_WIDTH (DATA_WIDTH),
         .DEPTH      (MAX_IMAGE_SIZE),
         .ADDR_W     (ADDR_W)
      ) u_slot (
         .clk     (clk),
         .wr_en   (slot_we[i]),
         .wr_addr (pix_cnt[ADDR_W-1:0]),
         .wr_data (s_axis_tdata),
         .rd_addr (col_m1[ADDR_W-1:0]),
         .rd_data (slot_rd[i])
      );
   end

   always_ff @(posedge clk) begin
      if (!rst_ok) state <= S_IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (Stream_first_row || Stream_mid_row) state_nxt = S_LOAD;
            else if (Stream_last_row)               state_nxt = S_EMIT;
         end
         S_LOAD: if (beat && row_end && rows_to_load == 2'd1) state_nxt = S_EMIT;
         S_EMIT: if (col_accept && col_is_last) state_nxt = S_DONE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_ok) begin
         ptr          <= 2'd0;
         pad_top      <= 1'b0;
         pad_bot      <= 1'b0;
         rows_to_load <= 2'd0;
         pix_cnt      <= 8'd0;
         col_cnt      <= 8'd0;
         img_size     <= 8'd0;
      end else begin
         case (state)
            S_IDLE: begin
               pix_cnt <= 8'd0;
               col_cnt <= 8'd0;
               if (Stream_first_row) begin
                  ptr          <= 2'd0;
                  pad_top      <= 1'b1;
                  pad_bot      <= 1'b0;
                  rows_to_load <= 2'd2;
                  img_size     <= IMAGE_SIZE;
               end else if (Stream_mid_row) begin
                  ptr          <= mod3_inc(ptr);
                  pad_top      <= 1'b0;
                  rows_to_load <= 2'd1;
                  img_size     <= IMAGE_SIZE;
               end else if (Stream_last_row) begin
                  ptr          <= mod3_inc(ptr);
                  pad_bot      <= 1'b1;
                  rows_to_load <= 2'd0;
                  img_size     <= IMAGE_SIZE;
               end
            end
            S_LOAD: begin
               if (beat) begin
                  if (row_end) begin
                     pix_cnt      <= 8'd0;
                     rows_to_load <= rows_to_load - 2'd1;
                  end else begin
                     pix_cnt <= pix_cnt + 8'd1;
                  end
               end
            end
            S_EMIT: if (col_accept) col_cnt <= col_cnt + 8'd1;
            default: col_cnt <= 8'd0;
         endcase
      end
   end

`ifdef ILB_TLAST_CHECK_EN
   always_ff @(posedge clk) begin
      if (!rst_ok)                             row_len_err <= 1'b0;
      else if (beat && (s_axis_tlast != row_end)) row_len_err <= 1'b1;
   end
   logic unused_bits;
   assign unused_bits = &{1'b0, col_m1[7:ADDR_W], pix_cnt[7:ADDR_W]};
`else
   assign row_len_err = 1'b0;
   logic unused_bits;
   assign unused_bits = &{1'b0, s_axis_tlast, col_m1[7:ADDR_W], pix_cnt[7:ADDR_W]};
`endif

   assign s_axis_tready          = (state == S_LOAD);
   assign m_col_valid            = (state == S_EMIT);
   assign Done_1row              = (state == S_DONE);
   assign Input_line_buffer_IDLE = (state == S_IDLE);
   assign m_col_first            = m_col_valid && col_is_first;
   assign m_col_last             = m_col_valid && col_is_last;
   assign m_col_top = (m_col_valid && !pad_col && !pad_top) ? slot_rd[top_idx] : '0;
   assign m_col_mid = (m_col_valid && !pad_col)             ? slot_rd[mid_idx] : '0;
   assign m_col_bot = (m_col_valid && !pad_col && !pad_bot) ? slot_rd[bot_idx] : '0;

endmodule

`default_nettype wire
